fifo_alu_dvfs: RTL

FIFO_ALU_DVFS -- requirements
Module: fifo_alu_dvfs

---
 rtl/fifo_alu_dvfs_pkg.sv | 40 ++++
 rtl/fifo_alu_dvfs_if.sv | 39 +++
 rtl/fifo_alu_dvfs_fifo.sv | 57 +++++
 rtl/fifo_alu_dvfs.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fifo_alu_dvfs_pkg.sv
// Shared definitions for the FIFO-fed ALU: opcodes, rate-select encodings and default widths.
package fifo_alu_pkg;

    localparam int DEF_OPD_W = 4;
    localparam int DEF_OP_W  = 4;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHR = 4'd8,
        OP_SHL = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        SEL_DIV1 = 2'b00,
        SEL_DIV2 = 2'b01,
        SEL_DIV4 = 2'b10,
        SEL_DIV8 = 2'b11
    } rate_sel_e;

    // Terminal divider count (R-1) for a given rate select.
    function automatic logic [2:0] div_max_of(input logic [1:0] sel);
        logic [2:0] max_cnt;
        case (sel)
            SEL_DIV1: max_cnt = 3'd0;
            SEL_DIV2: max_cnt = 3'd1;
            SEL_DIV4: max_cnt = 3'd3;
            default:  max_cnt = 3'd7;
        endcase
        return max_cnt;
    endfunction

endpackage

// File: rtl/fifo_alu_dvfs_if.sv
// Bus bundle between the instruction source and the FIFO-fed ALU.
interface fifo_alu_dvfs_if
    import fifo_alu_pkg::*;
#(
    parameter int OPD_W = DEF_OPD_W,
    parameter int OP_W  = DEF_OP_W,
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int INS_W = OP_W + 2 * OPD_W;
    localparam int RES_W = 2 * OPD_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [INS_W-1:0] instruction;
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       select;
    logic [INS_W-1:0] data_out;
    logic             data_empty;
    logic             data_full;
    logic [CNT_W-1:0] fifo_counter;
    logic [RES_W-1:0] result;
    logic             result_valid;
    logic             err;
    logic             clk_tick;

    modport master (
        output instruction, wr_en, rd_en, select,
        input  data_out, data_empty, data_full, fifo_counter,
               result, result_valid, err, clk_tick
    );

    modport slave (
        input  instruction, wr_en, rd_en, select,
        output data_out, data_empty, data_full, fifo_counter,
               result, result_valid, err, clk_tick
    );

endinterface

// File: rtl/fifo_alu_dvfs_fifo.sv
// Instruction FIFO: registered occupancy counter, no fall-through, write accepted at full on a pop.
module instr_fifo #(
    parameter int INS_W = 12,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [INS_W-1:0] wr_data,
    output logic [INS_W-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             wr_drop
);

    logic [INS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign wr_drop = push & ~do_push;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_alu_dvfs.sv
// FIFO-fed ALU whose execution rate is set by a strobe divider; one instruction per tick.
module fifo_alu_dvfs
    import fifo_alu_pkg::*;
#(
    parameter int OPD_W = DEF_OPD_W,
    parameter int OP_W  = DEF_OP_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic            clk,
    input logic            rst_n,
    fifo_alu_dvfs_if.slave bus
);

    localparam int INS_W = OP_W + 2 * OPD_W;
    localparam int RES_W = 2 * OPD_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [2:0]       div_cnt;
    logic [2:0]       div_max;
    logic             tick;
    logic             pop;
    logic             fifo_empty;
    logic             wr_drop;
    logic [INS_W-1:0] head;
    logic [OP_W-1:0]  op;
    logic [OPD_W-1:0] op_a;
    logic [OPD_W-1:0] op_b;
    logic [OPD_W-1:0] not_a;
    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [RES_W-1:0] alu_res;
    logic             alu_err;
    logic [INS_W-1:0] data_out_q;
    logic [RES_W-1:0] result_q;
    logic             result_valid_q;
    logic             err_q;

    // Gating with rst_n keeps the strobe low in reset and makes the first edge after release a tick.
    assign tick = rst_n & (div_cnt == div_max);
    assign pop  = tick & bus.rd_en & ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            div_max <= '0;
        end else if (tick) begin
            div_max <= div_max_of(bus.select);
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 3'd1;
        end
    end

    instr_fifo #(.INS_W(INS_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (bus.wr_en),
        .pop     (pop),
        .wr_data (bus.instruction),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (bus.data_full),
        .count   (bus.fifo_counter),
        .wr_drop (wr_drop)
    );

    assign op    = head[INS_W-1 -: OP_W];
    assign op_a  = head[2*OPD_W-1 -: OPD_W];
    assign op_b  = head[OPD_W-1:0];
    assign not_a = ~op_a;
    assign a_ext = RES_W'(op_a);
    assign b_ext = RES_W'(op_b);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op)
            OP_W'(OP_ADD): alu_res = a_ext + b_ext;
            OP_W'(OP_SUB): alu_res = a_ext - b_ext;
            OP_W'(OP_MUL): alu_res = a_ext * b_ext;
            OP_W'(OP_DIV): begin
                if (op_b == '0) begin
                    alu_res = '1;
                    alu_err = 1'b1;
                end else begin
                    alu_res = a_ext / b_ext;
                end
            end
            OP_W'(OP_AND): alu_res = a_ext & b_ext;
            OP_W'(OP_OR):  alu_res = a_ext | b_ext;
            OP_W'(OP_XOR): alu_res = a_ext ^ b_ext;
            OP_W'(OP_NOT): alu_res = RES_W'(not_a);
            OP_W'(OP_SHR): alu_res = a_ext >> 1;
            OP_W'(OP_SHL): alu_res = a_ext << 1;
            default:       alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            result_valid_q <= pop;
            err_q          <= wr_drop | (pop & alu_err);
            if (pop) begin
                data_out_q <= head;
                result_q   <= alu_res;
            end
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.err          = err_q;
    assign bus.clk_tick     = tick;
    assign bus.data_empty   = fifo_empty;

endmodule
